// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port, 4-cycle-latency main memory between the
// I-cache and D-cache miss handlers. Fills are 8 halfword reads of one 16-byte
// block; the D side may also issue one-word writes. Grant is locked to the
// owner until its transaction completes.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> 1-bit round-robin pointer breaks I/D ties (reset favours D)
//   undefined -> fixed priority, D always beats I
//
// Handshake: a requester raises *_req and holds it until *_done. The request is
// only sampled while the arbiter is IDLE. The *_grant output is high for every
// cycle that the requester owns memory. *_done pulses for one cycle, on the last
// cycle of the transaction. Dropping *_req after the grant does not abort the
// transaction. Read data is signalled by *_data_valid, which is mem_data_valid
// forwarded to the owner only.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        i_grant,
   output logic        d_grant,
   output logic        i_data_valid,
   output logic        d_data_valid,
   output logic        i_done,
   output logic        d_done,
   output logic [15:0] mem_addr,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_wdata,
   input  logic        mem_data_valid,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      I_FILL  = 2'd1,
      D_FILL  = 2'd2,
      D_WRITE = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [2:0]  ic;          // issue counter: word index of the next read
   logic [2:0]  rc;          // return counter: valids received so far
   logic        issue_busy;  // reads still to be issued in the current fill
   logic [11:0] blk;         // block number latched at grant
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        pick_d;      // D wins arbitration this cycle
   logic        is_fill;
   logic        last_valid;  // 8th read return of the current fill
   logic        start;       // leaving IDLE this cycle

   // Byte offset within the block is irrelevant for fills.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^i_addr[3:0];

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic        rr_d;        // 1: D wins the next tie, 0: I wins
`endif

   assign is_fill    = (state == I_FILL) || (state == D_FILL);
   assign last_valid = is_fill && mem_data_valid && (rc == 3'd7);
   assign start      = (state == IDLE) && (next_state != IDLE);
   assign dbg_state  = state;

   // Next-state logic: arbitration only in IDLE, transactions run to completion.
   always_comb begin
      next_state = state;
      pick_d     = 1'b0;
      case (state)
         IDLE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_d = d_req && (!i_req || rr_d);
`else
            pick_d = d_req;
`endif
            if (pick_d) begin
               next_state = d_wr ? D_WRITE : D_FILL;
            end else if (i_req) begin
               next_state = I_FILL;
            end
         end
         I_FILL, D_FILL: begin
            if (last_valid) begin
               next_state = IDLE;
            end
         end
         D_WRITE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Latch the transaction at grant, then step the issue and return counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         ic         <= 3'd0;
         rc         <= 3'd0;
         issue_busy <= 1'b0;
         blk        <= 12'd0;
         wr_addr    <= 16'd0;
         wr_data    <= 16'd0;
      end else if (start) begin
         ic         <= 3'd0;
         rc         <= 3'd0;
         issue_busy <= (next_state != D_WRITE);
         blk        <= pick_d ? d_addr[15:4] : i_addr[15:4];
         wr_addr    <= d_addr;
         wr_data    <= d_wdata;
      end else if (is_fill) begin
         if (issue_busy) begin
            ic <= ic + 3'd1;
            if (ic == 3'd7) begin
               issue_busy <= 1'b0;
            end
         end
         if (mem_data_valid) begin
            rc <= rc + 3'd1;
         end
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // After each completed transaction, favour the requester that was not served.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_d <= 1'b1;
      end else if (last_valid || (state == D_WRITE)) begin
         rr_d <= (state == I_FILL);
      end
   end
`endif

   // Outputs decoded from the registered state; valids are routed to the owner.
   always_comb begin
      i_grant      = 1'b0;
      d_grant      = 1'b0;
      i_data_valid = 1'b0;
      d_data_valid = 1'b0;
      i_done       = 1'b0;
      d_done       = 1'b0;
      mem_addr     = 16'd0;
      mem_enable   = 1'b0;
      mem_wr       = 1'b0;
      mem_wdata    = 16'd0;
      case (state)
         I_FILL: begin
            i_grant      = 1'b1;
            i_data_valid = mem_data_valid;
            i_done       = last_valid;
            if (issue_busy) begin
               mem_enable = 1'b1;
               mem_addr   = {blk, ic, 1'b0};
            end
         end
         D_FILL: begin
            d_grant      = 1'b1;
            d_data_valid = mem_data_valid;
            d_done       = last_valid;
            if (issue_busy) begin
               mem_enable = 1'b1;
               mem_addr   = {blk, ic, 1'b0};
            end
         end
         D_WRITE: begin
            d_grant    = 1'b1;
            d_done     = 1'b1;
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = wr_addr;
            mem_wdata  = wr_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle-by-cycle check of mem_arbiter against a transaction-level
// reference model (owner, grant cycle, block base) plus a 4-cycle memory model.
module tb_mem_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        i_grant, d_grant, i_data_valid, d_data_valid, i_done, d_done;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_enable, mem_wr, mem_data_valid;
   logic [1:0]  dbg_state;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .i_grant(i_grant), .d_grant(d_grant),
      .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
      .i_done(i_done), .d_done(d_done),
      .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_data_valid(mem_data_valid),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard / model state ----------------
   int checks = 0;
   int passes = 0;
   int cyc = 0;

   logic [15:0] exp_q[$];      // expected read addresses, in issue order
   logic [3:0]  mem_sh = 4'd0; // reads in flight inside the memory model
   bit          stray = 1'b0;

   int          own = 0;       // 0 none, 1 I, 2 D
   bit          wr_txn = 1'b0;
   int          g = 0;         // first granted cycle of the current transaction
   logic [15:0] m_waddr, m_wdata;
   bit          last_d = 1'b0; // last completed transaction was D
   bit          i_pend = 1'b0;
   bit          d_pend = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // One clock cycle: apply memory return, check outputs, advance the model.
   task automatic step(input bit zchk);
      bit act, een, ew, egi, egd, edvi, edvd, edi, edd, rd, pick_d;
      int k, endc;
      logic [15:0] base;
      mem_data_valid = mem_sh[3] | stray;
      act  = (own != 0) && (cyc >= g);
      k    = cyc - g;
      endc = wr_txn ? g : g + 11;
      egi  = act && (own == 1);
      egd  = act && (own == 2);
      een  = act && (wr_txn || k <= 7);
      ew   = act && wr_txn;
      edvi = egi && !wr_txn && k >= 4;
      edvd = egd && !wr_txn && k >= 4;
      edi  = egi && (cyc == endc);
      edd  = egd && (cyc == endc);
      @(negedge clk);
      check_eq("grant", 32'({i_grant, d_grant}), 32'({egi, egd}));
      check_eq("data_valid", 32'({i_data_valid, d_data_valid}), 32'({edvi, edvd}));
      check_eq("done", 32'({i_done, d_done}), 32'({edi, edd}));
      check_eq("mem_en_wr", 32'({mem_enable, mem_wr}), 32'({een, ew}));
      if (ew) begin
         check_eq("wr_addr", 32'(mem_addr), 32'(m_waddr));
         check_eq("wr_data", 32'(mem_wdata), 32'(m_wdata));
      end
      if (zchk) begin
         check_eq("zero_ctrl", 32'({i_grant, d_grant, i_data_valid, d_data_valid,
                                    i_done, d_done, mem_enable, mem_wr}), 32'(0));
         check_eq("zero_bus", {mem_addr, mem_wdata}, 32'(0));
      end
      rd = mem_enable && !mem_wr;
      if (rd) begin
         check_eq("rd_expected", 32'(exp_q.size() != 0), 32'(1));
         if (exp_q.size() != 0) check_eq("rd_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
      end
      // model update for the next cycle
      if (rst) begin
         own = 0; last_d = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
         exp_q.delete();
      end else if (act && cyc == endc) begin
         last_d = (own == 2);
         if (own == 1) i_pend = 1'b0; else d_pend = 1'b0;
         own = 0;
      end else if (own == 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         pick_d = d_req && (!i_req || !last_d);
`else
         pick_d = d_req;
`endif
         if (pick_d || i_req) begin
            own     = pick_d ? 2 : 1;
            wr_txn  = pick_d && d_wr;
            g       = cyc + 1;
            m_waddr = d_addr;
            m_wdata = d_wdata;
            base    = (pick_d ? d_addr : i_addr) & 16'hFFF0;
            if (!wr_txn)
               for (int j = 0; j < 8; j++) exp_q.push_back(base + 16'(2 * j));
         end
      end
      @(posedge clk);
      #1;
      mem_sh = {mem_sh[2:0], rd};
      stray  = 1'b0;
      cyc++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic raise_i(input logic [15:0] a);
      i_req = 1'b1; i_addr = a; i_pend = 1'b1;
   endtask

   task automatic raise_d(input bit w, input logic [15:0] a, input logic [15:0] wd);
      d_req = 1'b1; d_wr = w; d_addr = a; d_wdata = wd; d_pend = 1'b1;
   endtask

   task automatic drop_finished();
      if (!i_pend) i_req = 1'b0;
      if (!d_pend) begin d_req = 1'b0; d_wr = 1'b0; end
   endtask

   task automatic run_txns(input int budget);
      int n = 0;
      while ((i_pend || d_pend) && n < budget) begin
         step(1'b0);
         drop_finished();
         n++;
      end
      check_eq("txn_budget", 32'(i_pend | d_pend), 32'(0));
      step(1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      i_addr = 16'd0; d_addr = 16'd0; d_wdata = 16'd0; mem_data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      step(1'b1);
      rst = 1'b0;
      step(1'b1);

      // single I fill
      raise_i(16'h1236);
      run_txns(40);

      // tie: D fill vs I fill
      raise_i(16'h5558);
      raise_d(1'b0, 16'h0040, 16'h0);
      run_txns(60);

      // two back-to-back ties
      raise_i(16'h7702);
      raise_d(1'b0, 16'h8814, 16'h0);
      run_txns(60);
      raise_i(16'h99A0);
      raise_d(1'b0, 16'hAB3F, 16'h0);
      run_txns(60);

      // D write
      raise_d(1'b1, 16'h0F02, 16'hBEEF);
      run_txns(10);

      // reset in the middle of an I fill
      raise_i(16'h2468);
      step(1'b0);
      repeat (5) step(1'b0);
      rst = 1'b1; i_req = 1'b0;
      step(1'b0);
      rst = 1'b0;
      step(1'b1);
      repeat (7) step(1'b0);
      raise_d(1'b0, 16'h3004, 16'h0);
      run_txns(40);

      // stray valid while idle, then a normal fill
      stray = 1'b1;
      step(1'b0);
      raise_i(16'hC0DE);
      run_txns(40);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         if (!i_pend && $urandom_range(0, 3) == 0) raise_i(16'($urandom));
         else if (i_pend && own == 1 && $urandom_range(0, 7) == 0) i_req = 1'b0;
         if (!d_pend && $urandom_range(0, 3) == 0)
            raise_d(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
         else if (d_pend && own == 2 && $urandom_range(0, 7) == 0) d_req = 1'b0;
         step(1'b0);
         drop_finished();
      end
      run_txns(80);

      check_eq("exp_q_empty", 32'(exp_q.size()), 32'(0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
